// File: rtl/dmem_pkg.sv
// Shared definitions for the Data_Memory arbiter: access modes, FSM states,
// and the misalignment rule used when DMEM_ARB_MISALIGN_CHECK_EN is defined.
package dmem_pkg;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] addr_lo);
    return ((mode[1:0] == 2'b01) && addr_lo[0]) ||
           ((mode[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way request picker: round-robin when fair is set, otherwise port 0 wins.
// Purely combinational; the caller owns the "last served" state.
module dmem_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fair,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    // Contention: serve the port that was not served last, or port 0 when unfair.
    if (req == 2'b11) begin
      grant = (fair && !last) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported Data_Memory (IDLE -> ACCESS -> IDLE).
// Define DMEM_ARB_MISALIGN_CHECK_EN to suppress and flag misaligned halfword/word accesses.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FAIR   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [2:0]        r0_mode,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [2:0]        r1_mode,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [2:0]        mem_mode,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic FAIR_EN = (FAIR != 0);

  state_t            state;
  logic              rr_last;
  logic              owner;
  logic              acc_load;
  logic              acc_err;
  logic [1:0]        pick;
  logic [1:0]        grant;
  logic              win;
  logic              w_we;
  logic              w_mis;
  logic [2:0]        w_mode;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  dmem_arb_rr u_rr (
    .req   ({r1_req, r0_req}),
    .last  (rr_last),
    .fair  (FAIR_EN),
    .grant (pick)
  );

  always_comb begin
    grant   = (!reset && state == ST_IDLE) ? pick : 2'b00;
    win     = grant[1];
    w_we    = win ? r1_we    : r0_we;
    w_mode  = win ? r1_mode  : r0_mode;
    w_addr  = win ? r1_addr  : r0_addr;
    w_wdata = win ? r1_wdata : r0_wdata;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    w_mis   = is_misaligned(w_mode, w_addr[1:0]);
`else
    w_mis   = 1'b0;
`endif
  end

  assign r0_gnt = grant[0];
  assign r1_gnt = grant[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_last   <= 1'b1;
      owner     <= 1'b0;
      acc_load  <= 1'b0;
      acc_err   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_mode  <= '0;
      mem_wdata <= '0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      r0_err    <= 1'b0;
      r1_err    <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      r0_err  <= 1'b0;
      r1_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          mem_we <= 1'b0;
          if (grant != 2'b00) begin
            state     <= ST_ACCESS;
            rr_last   <= win;
            owner     <= win;
            mem_addr  <= w_addr;
            mem_mode  <= w_mode;
            mem_wdata <= w_wdata;
            // A flagged access still takes its slot but never touches memory.
            mem_we    <= w_we & ~w_mis;
            acc_load  <= ~w_we & ~w_mis;
            acc_err   <= w_mis;
          end
        end
        ST_ACCESS: begin
          state  <= ST_IDLE;
          mem_we <= 1'b0;
          if (owner) begin
            r1_done <= 1'b1;
            r1_err  <= acc_err;
            if (acc_load) r1_rdata <= mem_rdata;
          end else begin
            r0_done <= 1'b1;
            r0_err  <= acc_err;
            if (acc_load) r0_rdata <= mem_rdata;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized two-port traffic against a
// transaction-level model (byte-array memory, busy counter, round-robin "last served" bit).
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_pkg::*;

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req, we;
  logic [2:0]  mode [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [1:0]  gnt, done, err;
  logic [31:0] rdata [2];
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [2:0]  mem_mode;

  logic [1:0]  gnt_f, done_f, err_f;
  logic [31:0] rdata_f [2];
  logic [31:0] maddr_f, mwdata_f, mrdata_f;
  logic        mwe_f;
  logic [2:0]  mmode_f;

  int vectors = 0;
  int miscompares = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(1)) u_dut (
    .clk(clk), .reset(reset),
    .r0_req(req[0]), .r0_we(we[0]), .r0_mode(mode[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
    .r0_gnt(gnt[0]), .r0_done(done[0]), .r0_rdata(rdata[0]), .r0_err(err[0]),
    .r1_req(req[1]), .r1_we(we[1]), .r1_mode(mode[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
    .r1_gnt(gnt[1]), .r1_done(done[1]), .r1_rdata(rdata[1]), .r1_err(err[1]),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_mode(mem_mode), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR(0)) u_fix (
    .clk(clk), .reset(reset),
    .r0_req(req[0]), .r0_we(we[0]), .r0_mode(mode[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
    .r0_gnt(gnt_f[0]), .r0_done(done_f[0]), .r0_rdata(rdata_f[0]), .r0_err(err_f[0]),
    .r1_req(req[1]), .r1_we(we[1]), .r1_mode(mode[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
    .r1_gnt(gnt_f[1]), .r1_done(done_f[1]), .r1_rdata(rdata_f[1]), .r1_err(err_f[1]),
    .mem_addr(maddr_f), .mem_we(mwe_f), .mem_mode(mmode_f), .mem_wdata(mwdata_f),
    .mem_rdata(mrdata_f)
  );

  assign mrdata_f = maddr_f ^ 32'h5A5A_0000;

  // Environment Data_Memory: 64 little-endian words, combinational read, commit on clk.
  logic [31:0] wmem [64];
  logic [31:0] env_word;
  logic        mem_clr = 1'b0;

  always_comb begin
    env_word = wmem[mem_addr[7:2]] >> {mem_addr[1:0], 3'b000};
    case (mem_mode)
      MODE_B:  mem_rdata = {{24{env_word[7]}}, env_word[7:0]};
      MODE_BU: mem_rdata = {24'h0, env_word[7:0]};
      MODE_H:  mem_rdata = {{16{env_word[15]}}, env_word[15:0]};
      MODE_HU: mem_rdata = {16'h0, env_word[15:0]};
      default: mem_rdata = env_word;
    endcase
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) wmem[i] <= '0;
    end else if (mem_we) begin
      case (mem_mode[1:0])
        2'b00:   wmem[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8]  <= mem_wdata[7:0];
        2'b01:   wmem[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 16] <= mem_wdata[15:0];
        default: wmem[mem_addr[7:2]] <= mem_wdata;
      endcase
    end
  end

  // Reference model state.
  logic [7:0]  ref_mem [256];
  logic        m_last;
  logic [31:0] m_rdata [2];

  function automatic int nbytes(input logic [2:0] m);
    return (m[1:0] == 2'b00) ? 1 : (m[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] m);
    int n;
    logic [31:0] v;
    n = nbytes(m);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[8'(a + 32'(i))]) << (8 * i));
    if (!m[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] m, input logic [31:0] d);
    for (int i = 0; i < nbytes(m); i++) ref_mem[8'(a + 32'(i))] = d[8*i +: 8];
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endtask

  task automatic issue(input int p, input logic w, input logic [2:0] m,
                       input logic [31:0] a, input logic [31:0] d);
    we[p] = w; mode[p] = m; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_clr = 1'b1;
    issue(0, 1'b1, MODE_W, 32'h10, 32'h1234_5678);
    issue(1, 1'b0, MODE_W, 32'h20, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    vectors++; if (gnt_f !== 2'b00) begin miscompares++; $display("FAIL reset_gnt_fix: got %b want 00", gnt_f); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    vectors++; if ({mem_addr, mem_mode, mem_wdata} !== 67'h0) begin miscompares++; $display("FAIL reset_mem_cmd: got %h/%b/%h want 0", mem_addr, mem_mode, mem_wdata); end
    vectors++; if ({done, err} !== 4'h0) begin miscompares++; $display("FAIL reset_done_err: got %b/%b want 00/00", done, err); end
    vectors++; if ({rdata[0], rdata[1]} !== 64'h0) begin miscompares++; $display("FAIL reset_rdata: got %h/%h want 0", rdata[0], rdata[1]); end
    req = '0; mem_clr = 1'b0;
    ref_clear();
    m_last = 1'b1; m_rdata[0] = '0; m_rdata[1] = '0;
    @(negedge clk); reset = 1'b0;
    idle(1);
  endtask

  task automatic test_store_load();
    @(negedge clk); issue(0, 1'b1, MODE_W, 32'd4, 32'hF00A_A00F); #1;
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL sl_store_gnt: got %b want 01", gnt); end
    ref_store(32'd4, MODE_W, 32'hF00A_A00F); m_last = 1'b0;
    @(negedge clk); req[0] = 1'b0; #1;
    vectors++; if ({mem_we, mem_addr, mem_mode, mem_wdata} !== {1'b1, 32'd4, MODE_W, 32'hF00A_A00F}) begin miscompares++; $display("FAIL sl_store_cmd: got we=%b a=%h m=%b d=%h want 1/4/010/F00AA00F", mem_we, mem_addr, mem_mode, mem_wdata); end
    vectors++; if (done !== 2'b00) begin miscompares++; $display("FAIL sl_store_early_done: got %b want 00", done); end
    @(negedge clk); issue(0, 1'b0, MODE_W, 32'd4, 32'h0); #1;
    vectors++; if (done !== 2'b01) begin miscompares++; $display("FAIL sl_store_done: got %b want 01", done); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL sl_we_one_cycle: got %b want 0", mem_we); end
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL sl_load_gnt: got %b want 01", gnt); end
    @(negedge clk); req[0] = 1'b0; #1;
    vectors++; if ({mem_we, mem_addr} !== {1'b0, 32'd4}) begin miscompares++; $display("FAIL sl_load_cmd: got we=%b a=%h want 0/4", mem_we, mem_addr); end
    @(negedge clk); #1;
    m_rdata[0] = ref_load(32'd4, MODE_W);
    vectors++; if (done !== 2'b01) begin miscompares++; $display("FAIL sl_load_done: got %b want 01", done); end
    vectors++; if (rdata[0] !== m_rdata[0]) begin miscompares++; $display("FAIL sl_load_rdata: got %h want %h", rdata[0], m_rdata[0]); end
    idle(2);
  endtask

  task automatic test_byte_lanes();
    logic [31:0] a_tab [3];
    logic [2:0]  m_tab [3];
    logic [31:0] d_tab [3];
    a_tab = '{32'd10, 32'd11, 32'd8};
    m_tab = '{MODE_B, MODE_B, MODE_W};
    d_tab = '{32'h0000_00AA, 32'h0000_00BB, 32'h0};
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0; ref_clear();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); issue(1, (k < 2), m_tab[k], a_tab[k], d_tab[k]); #1;
      vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL bl_gnt%0d: got %b want 10", k, gnt); end
      m_last = 1'b1;
      if (k < 2) ref_store(a_tab[k], m_tab[k], d_tab[k]);
      @(negedge clk); req[1] = 1'b0; #1;
      vectors++; if ({mem_mode, mem_we} !== {m_tab[k], (k < 2)}) begin miscompares++; $display("FAIL bl_mode%0d: got %b/%b want %b/%b", k, mem_mode, mem_we, m_tab[k], (k < 2)); end
      @(negedge clk); #1;
      vectors++; if (done !== 2'b10) begin miscompares++; $display("FAIL bl_done%0d: got %b want 10", k, done); end
    end
    m_rdata[1] = ref_load(32'd8, MODE_W);
    vectors++; if (rdata[1] !== m_rdata[1]) begin miscompares++; $display("FAIL bl_rdata: got %h want %h", rdata[1], m_rdata[1]); end
    idle(2);
  endtask

  task automatic test_fair();
    logic [1:0] eg, ef, ed, edf;
    int pw;
    pw = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin issue(0, 1'b0, MODE_W, 32'd0, 32'h0); issue(1, 1'b0, MODE_W, 32'd8, 32'h0); end
      #1;
      eg = 2'b00; ef = 2'b00;
      if (i % 2 == 0) begin eg = m_last ? 2'b01 : 2'b10; ef = 2'b01; end
      ed = (i >= 2 && i % 2 == 0) ? (2'b01 << pw) : 2'b00;
      edf = (i >= 2 && i % 2 == 0) ? 2'b01 : 2'b00;
      if (ed != 2'b00) m_rdata[pw] = ref_load(pw == 1 ? 32'd8 : 32'd0, MODE_W);
      vectors++; if (gnt !== eg) begin miscompares++; $display("FAIL fair_gnt c%0d: got %b want %b", i, gnt, eg); end
      vectors++; if (gnt_f !== ef) begin miscompares++; $display("FAIL fixed_gnt c%0d: got %b want %b", i, gnt_f, ef); end
      vectors++; if (done !== ed) begin miscompares++; $display("FAIL fair_done c%0d: got %b want %b", i, done, ed); end
      vectors++; if (done_f !== edf) begin miscompares++; $display("FAIL fixed_done c%0d: got %b want %b", i, done_f, edf); end
      vectors++; if ({rdata[0], rdata[1]} !== {m_rdata[0], m_rdata[1]}) begin miscompares++; $display("FAIL fair_rdata c%0d: got %h/%h want %h/%h", i, rdata[0], rdata[1], m_rdata[0], m_rdata[1]); end
      if (edf != 2'b00) begin
        vectors++; if (rdata_f[0] !== (32'd0 ^ 32'h5A5A_0000)) begin miscompares++; $display("FAIL fixed_rdata c%0d: got %h want 5a5a0000", i, rdata_f[0]); end
      end
      if (eg != 2'b00) begin pw = int'(eg[1]); m_last = eg[1]; end
    end
    req = '0;
    m_rdata[pw] = ref_load(pw == 1 ? 32'd8 : 32'd0, MODE_W);
    idle(3);
  endtask

  task automatic test_contention();
    @(negedge clk); issue(0, 1'b0, MODE_W, 32'd0, 32'h0); #1;
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL ct_gnt0: got %b want 01", gnt); end
    m_last = 1'b0;
    @(negedge clk); req[0] = 1'b0; issue(1, 1'b0, MODE_W, 32'd8, 32'h0); #1;
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL ct_access_gnt: got %b want 00", gnt); end
    @(negedge clk); #1;
    vectors++; if ({done, gnt} !== 4'b0110) begin miscompares++; $display("FAIL ct_done_gnt: got done=%b gnt=%b want 01/10", done, gnt); end
    m_last = 1'b1; m_rdata[0] = ref_load(32'd0, MODE_W);
    @(negedge clk); req[1] = 1'b0;
    @(negedge clk); #1;
    m_rdata[1] = ref_load(32'd8, MODE_W);
    vectors++; if (done !== 2'b10) begin miscompares++; $display("FAIL ct_done1: got %b want 10", done); end
    vectors++; if (rdata[1] !== m_rdata[1]) begin miscompares++; $display("FAIL ct_rdata1: got %h want %h", rdata[1], m_rdata[1]); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); issue(0, 1'b1, MODE_W, 32'd200, $urandom); #1;
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL rm_gnt: got %b want 01", gnt); end
    @(negedge clk); req[0] = 1'b0; #1;
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL rm_we_before: got %b want 1", mem_we); end
    reset = 1'b1; #1;
    vectors++; if ({mem_we, mwe_f} !== 2'b00) begin miscompares++; $display("FAIL rm_we_async: got %b/%b want 0/0", mem_we, mwe_f); end
    m_last = 1'b1; m_rdata[0] = '0; m_rdata[1] = '0;
    @(negedge clk); issue(0, 1'b0, MODE_W, 32'd8, 32'h0); issue(1, 1'b0, MODE_W, 32'd0, 32'h0); #1;
    vectors++; if ({gnt, done} !== 4'b0000) begin miscompares++; $display("FAIL rm_in_reset: got gnt=%b done=%b want 00/00", gnt, done); end
    @(negedge clk); reset = 1'b0; #1;
    vectors++; if ({gnt, gnt_f} !== 4'b0101) begin miscompares++; $display("FAIL rm_after_gnt: got %b/%b want 01/01", gnt, gnt_f); end
    vectors++; if ({done, rdata[0], rdata[1]} !== {2'b00, m_rdata[0], m_rdata[1]}) begin miscompares++; $display("FAIL rm_no_done: got done=%b rdata=%h/%h want 00/0/0", done, rdata[0], rdata[1]); end
    m_last = 1'b0;
    @(negedge clk); req = '0; #1;
    vectors++; if (done !== 2'b00) begin miscompares++; $display("FAIL rm_access_done: got %b want 00", done); end
    @(negedge clk); #1;
    m_rdata[0] = ref_load(32'd8, MODE_W);
    vectors++; if ({done, rdata[0]} !== {2'b01, m_rdata[0]}) begin miscompares++; $display("FAIL rm_load: got done=%b rdata=%h want 01/%h", done, rdata[0], m_rdata[0]); end
    idle(2);
  endtask

  task automatic test_random();
    int busy, w, sz;
    int due [2];
    logic isld [2];
    logic [31:0] nxt [2];
    logic [1:0] eg, ed, taken;
    logic [2:0] modes [5];
    modes = '{MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU};
    busy = 0; due = '{-1, -1}; isld = '{1'b0, 1'b0}; nxt = '{32'h0, 32'h0}; taken = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req = req & ~taken;
      for (int p = 0; p < 2; p++) begin
        if (!req[p] && c < 396 && $urandom_range(0, 2) != 0) begin
          mode[p] = modes[$urandom_range(0, 4)];
          sz = nbytes(mode[p]);
          issue(p, 1'($urandom_range(0, 1)), mode[p], 32'($urandom_range(0, 127)) & ~32'(sz - 1), $urandom);
        end
      end
      #1;
      ed = '0;
      for (int p = 0; p < 2; p++) begin
        if (due[p] == c) begin
          ed[p] = 1'b1; due[p] = -1;
          if (isld[p]) m_rdata[p] = nxt[p];
        end
      end
      eg = '0;
      if (busy > 0) busy--;
      else if (req != 2'b00) begin
        w = (req == 2'b11) ? int'(!m_last) : int'(req[1]);
        eg[w] = 1'b1; m_last = 1'(w); busy = 1; due[w] = c + 2; isld[w] = !we[w];
        if (we[w]) ref_store(addr[w], mode[w], wdata[w]);
        else nxt[w] = ref_load(addr[w], mode[w]);
      end
      taken = eg;
      vectors++; if (gnt !== eg) begin miscompares++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, eg); end
      vectors++; if (done !== ed) begin miscompares++; $display("FAIL rnd_done c%0d: got %b want %b", c, done, ed); end
      vectors++; if (rdata[0] !== m_rdata[0]) begin miscompares++; $display("FAIL rnd_rdata0 c%0d: got %h want %h", c, rdata[0], m_rdata[0]); end
      vectors++; if (rdata[1] !== m_rdata[1]) begin miscompares++; $display("FAIL rnd_rdata1 c%0d: got %h want %h", c, rdata[1], m_rdata[1]); end
      vectors++; if (err !== 2'b00) begin miscompares++; $display("FAIL rnd_err c%0d: got %b want 00", c, err); end
    end
    idle(2);
  endtask

  task automatic test_misalign();
    logic [31:0] exp_rd;
    @(negedge clk); issue(0, 1'b0, MODE_W, 32'd5, 32'h0); #1;
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL ma_load_gnt: got %b want 01", gnt); end
    m_last = 1'b0;
    exp_rd = MIS_EN ? m_rdata[0] : {8'h00, ref_mem[7], ref_mem[6], ref_mem[5]};
    @(negedge clk); req[0] = 1'b0; #1;
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL ma_load_we: got %b want 0", mem_we); end
    @(negedge clk); #1;
    vectors++; if ({done, err} !== {2'b01, 1'b0, MIS_EN}) begin miscompares++; $display("FAIL ma_load_done_err: got %b/%b want 01/0%b", done, err, MIS_EN); end
    vectors++; if (rdata[0] !== exp_rd) begin miscompares++; $display("FAIL ma_load_rdata: got %h want %h", rdata[0], exp_rd); end
    @(negedge clk); issue(0, 1'b1, MODE_W, 32'd130, $urandom); #1;
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL ma_store_gnt: got %b want 01", gnt); end
    @(negedge clk); req[0] = 1'b0; #1;
    vectors++; if (mem_we !== !MIS_EN) begin miscompares++; $display("FAIL ma_store_we: got %b want %b", mem_we, !MIS_EN); end
    @(negedge clk); #1;
    vectors++; if ({done, err} !== {2'b01, 1'b0, MIS_EN}) begin miscompares++; $display("FAIL ma_store_done_err: got %b/%b want 01/0%b", done, err, MIS_EN); end
    idle(2);
  endtask

  initial begin
    req = '0; we = '0;
    mode[0] = '0; mode[1] = '0; addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_fair();
    test_contention();
    test_reset_mid();
    test_random();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
